// File: rtl/peripheral_result_fifo.sv
// Result-report FIFO between a core's to_peripheral* outputs and a host consumer.
// The core has no backpressure, so excess writes are dropped, counted and flagged.
module peripheral_result_fifo #(
  parameter int unsigned CORE       = 0,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH_BITS = 3,
  parameter int unsigned DROP_BITS  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [1:0]            in_port,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [1:0]            out_port,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [DEPTH_BITS:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic [DROP_BITS-1:0]  drop_count,
  input  logic                  clear,
  input  logic                  report
);

  localparam int unsigned            Depth    = 2 ** DEPTH_BITS;
  localparam logic [DEPTH_BITS:0]    DepthCnt = (DEPTH_BITS + 1)'(Depth);
  localparam logic [DEPTH_BITS:0]    CntOne   = (DEPTH_BITS + 1)'(1);
  localparam logic [DEPTH_BITS-1:0]  PtrOne   = DEPTH_BITS'(1);
  localparam logic [DROP_BITS-1:0]   DropOne  = DROP_BITS'(1);

  logic [DATA_WIDTH+1:0]  mem_q [Depth];
  logic [DATA_WIDTH+1:0]  head;

  logic [DEPTH_BITS-1:0]  wr_ptr_q, wr_ptr_d;
  logic [DEPTH_BITS-1:0]  rd_ptr_q, rd_ptr_d;
  logic [DEPTH_BITS:0]    count_q, count_d;
  logic                   overflow_q, overflow_d;
  logic [DROP_BITS-1:0]   drop_q, drop_d;

  logic pop, push, drop, push_en;

  assign empty = (count_q == '0);
  assign full  = (count_q == DepthCnt);

  assign pop  = !empty && out_ready;
  assign push = in_valid && (!full || pop);
  assign drop = in_valid && full && !pop;

  // A clear in the same cycle suppresses the array write as well as the pointer moves.
  assign push_en = push && !clear;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    drop_d     = drop_q;
    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      drop_d     = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrOne;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrOne;
      end
      if (push && !pop) begin
        count_d = count_q + CntOne;
      end else if (pop && !push) begin
        count_d = count_q - CntOne;
      end
      if (drop) begin
        overflow_d = 1'b1;
        if (drop_q != '1) begin
          drop_d = drop_q + DropOne;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  // Storage carries no reset; stale contents are never visible because the head is gated.
  always_ff @(posedge clock) begin
    if (push_en) begin
      mem_q[wr_ptr_q] <= {in_port, in_data};
    end
  end

  always_comb begin
    head      = mem_q[rd_ptr_q];
    out_valid = !empty;
    out_port  = '0;
    out_data  = '0;
    if (!empty) begin
      out_port = head[DATA_WIDTH+1:DATA_WIDTH];
      out_data = head[DATA_WIDTH-1:0];
    end
  end

  assign count      = count_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_q;

`ifndef SYNTHESIS
  always_ff @(posedge clock) begin
    if (report) begin
      $display("peripheral_result_fifo core %0d: count=%0d drop_count=%0d",
               CORE, count_q, drop_q);
    end
  end
`endif

endmodule
